vmicro16_uart_rx_apb: RTL and testbench

UART receiver exposed as an APB slave on the shared peripheral bus, the receive-side counterpart of the UART0 transmitter. Samples the asynchronous `rx_wire` line, deframes 8N1 bytes and buffers them in a small FIFO. Cores read the FIFO through zero-wait APB reads. `irq` is asserted while data is pending.

---
 rtl/vmicro16_uart_rx_apb_pkg.sv | 21 ++
 rtl/vmicro16_uart_rx_apb_if.sv | 17 +
 rtl/vmicro16_fifo_sync.sv | 52 +++++
 rtl/vmicro16_uart_rx_apb.sv | 148 ++++++++++++++
 tb/tb_vmicro16_uart_rx_apb.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/vmicro16_uart_rx_apb_pkg.sv
// Shared configuration for the APB UART receiver: register map, status bits, slave index.
package vmicro16_uart_rx_apb_pkg;
    localparam int DATA_WIDTH = 16;

    // UART1 takes the next free select line on the peripheral bus.
    localparam int APB_PSELX_UART1 = 8;
    localparam int SLAVES          = 9;

    localparam logic [1:0] UART_RX_ADDR_DATA   = 2'd0;
    localparam logic [1:0] UART_RX_ADDR_STATUS = 2'd1;
    localparam logic [1:0] UART_RX_ADDR_COUNT  = 2'd2;

    localparam int UART_RX_STAT_NEMPTY = 0;
    localparam int UART_RX_STAT_FULL   = 1;
    localparam int UART_RX_STAT_OVR    = 2;
    localparam int UART_RX_STAT_FERR   = 3;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/vmicro16_uart_rx_apb_if.sv
// APB slave-side signal bundle for the UART receiver.
interface vmicro16_uart_rx_apb_if
    import vmicro16_uart_rx_apb_pkg::*;
#(parameter int DW = DATA_WIDTH);
    logic [1:0]    S_PADDR;
    logic          S_PWRITE;
    logic          S_PSELx;
    logic          S_PENABLE;
    logic [DW-1:0] S_PWDATA;
    logic [DW-1:0] S_PRDATA;
    logic          S_PREADY;

    modport master (output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
                    input  S_PRDATA, S_PREADY);
    modport slave  (input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
                    output S_PRDATA, S_PREADY);
endinterface

// File: rtl/vmicro16_fifo_sync.sv
// Generic synchronous FIFO; head is combinational, push while full succeeds only alongside a pop.
module vmicro16_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd];
    assign w_do_pop  = i_pop & ~o_empty;
    // When full, the pop frees the slot the push writes into (r_wr == r_rd).
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/vmicro16_uart_rx_apb.sv
// 8N1 UART receiver with a receive FIFO, read by cores as a zero-wait APB slave.
module vmicro16_uart_rx_apb
    import vmicro16_uart_rx_apb_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    vmicro16_uart_rx_apb_if.slave         apb,
    input  logic                          rx_wire,
    output logic                          irq
);
    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int TW  = $clog2(CPB);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] T_HALF = TW'(CPB/2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CPB - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } rx_state_t;

    rx_state_t       r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bitidx;
    logic [7:0]      r_shift;
    logic            r_sync1, r_sync2;
    logic            r_ovr, r_ferr;

    logic            w_rx_s;
    logic            w_tick;
    logic            w_push, w_ferr_set;
    logic            w_en, w_rd, w_wr;
    logic            w_pop;
    logic            w_full, w_empty;
    logic [7:0]      w_head;
    logic [CW-1:0]   w_count;
    logic            w_ovr_set;
    logic            w_clr_ovr, w_clr_ferr;
    logic [DATA_WIDTH-1:0] w_prdata;
    logic            w_unused;

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_wire;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick     = (r_timer == '0);
    assign w_push     = (r_state == S_STOP) & w_tick & w_rx_s;
    assign w_ferr_set = (r_state == S_STOP) & w_tick & ~w_rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_bitidx <= '0;
            r_shift  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (!w_rx_s) begin
                    r_timer <= T_HALF;
                    r_state <= S_START;
                end
                S_START: if (w_tick) begin
                    if (w_rx_s) r_state <= S_IDLE;
                    else begin
                        r_timer  <= T_FULL;
                        r_bitidx <= '0;
                        r_state  <= S_DATA;
                    end
                end else r_timer <= r_timer - TW'(1);
                S_DATA: if (w_tick) begin
                    r_shift <= {w_rx_s, r_shift[7:1]};
                    r_timer <= T_FULL;
                    if (r_bitidx == 3'd7) r_state <= S_STOP;
                    else                  r_bitidx <= r_bitidx + 3'd1;
                end else r_timer <= r_timer - TW'(1);
                S_STOP: if (w_tick) r_state <= w_rx_s ? S_IDLE : S_BREAK;
                        else        r_timer <= r_timer - TW'(1);
                S_BREAK: if (w_rx_s) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_en  = apb.S_PSELx & apb.S_PENABLE;
    assign w_rd  = w_en & ~apb.S_PWRITE;
    assign w_wr  = w_en &  apb.S_PWRITE;
    assign w_pop = w_rd & (apb.S_PADDR == UART_RX_ADDR_DATA);

    vmicro16_fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A pop in the same cycle makes room, so only a pop-less push while full is an overrun.
    assign w_ovr_set  = w_push & w_full & ~w_pop;
    assign w_clr_ovr  = w_wr & (apb.S_PADDR == UART_RX_ADDR_STATUS) & apb.S_PWDATA[UART_RX_STAT_OVR];
    assign w_clr_ferr = w_wr & (apb.S_PADDR == UART_RX_ADDR_STATUS) & apb.S_PWDATA[UART_RX_STAT_FERR];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovr  <= (r_ovr  & ~w_clr_ovr)  | w_ovr_set;
            r_ferr <= (r_ferr & ~w_clr_ferr) | w_ferr_set;
        end
    end

    always_comb begin
        w_prdata = '0;
        if (w_rd) begin
            case (apb.S_PADDR)
                UART_RX_ADDR_DATA:   if (!w_empty) w_prdata = DATA_WIDTH'(w_head);
                UART_RX_ADDR_STATUS: begin
                    w_prdata[UART_RX_STAT_NEMPTY] = ~w_empty;
                    w_prdata[UART_RX_STAT_FULL]   = w_full;
                    w_prdata[UART_RX_STAT_OVR]    = r_ovr;
                    w_prdata[UART_RX_STAT_FERR]   = r_ferr;
                end
                UART_RX_ADDR_COUNT:  w_prdata = DATA_WIDTH'(w_count);
                default:             w_prdata = '0;
            endcase
        end
    end

    assign apb.S_PRDATA = w_prdata;
    assign apb.S_PREADY = w_en;
    assign irq          = ~w_empty;
    assign w_unused     = ^apb.S_PWDATA;
endmodule

// File: tb/tb_vmicro16_uart_rx_apb.sv
// Directed bench for the APB UART receiver at 8 clocks per bit.
module tb_vmicro16_uart_rx_apb;
    import vmicro16_uart_rx_apb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx_wire = 1'b1;
    logic irq;
    int   n_chk = 0;
    int   n_err = 0;
    logic [15:0] d;

    vmicro16_uart_rx_apb_if #(.DW(16)) apb_if ();

    vmicro16_uart_rx_apb #(.CLK_HZ(800), .BAUD(100), .FIFO_DEPTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .apb     (apb_if.slave),
        .rx_wire (rx_wire),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All bus/line tasks start and end on a falling clock edge.
    task automatic apb_rd(input logic [1:0] a, output logic [15:0] q);
        apb_if.S_PADDR = a; apb_if.S_PWRITE = 1'b0;
        apb_if.S_PSELx = 1'b1; apb_if.S_PENABLE = 1'b0;
        @(negedge clk);
        apb_if.S_PENABLE = 1'b1;
        #1 q = apb_if.S_PRDATA;
        @(negedge clk);
        apb_if.S_PSELx = 1'b0; apb_if.S_PENABLE = 1'b0;
    endtask

    task automatic apb_wr(input logic [1:0] a, input logic [15:0] v);
        apb_if.S_PADDR = a; apb_if.S_PWRITE = 1'b1; apb_if.S_PWDATA = v;
        apb_if.S_PSELx = 1'b1; apb_if.S_PENABLE = 1'b0;
        @(negedge clk);
        apb_if.S_PENABLE = 1'b1;
        @(negedge clk);
        apb_if.S_PSELx = 1'b0; apb_if.S_PENABLE = 1'b0; apb_if.S_PWRITE = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit stop_lo);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            rx_wire = fr[i];
            repeat (8) @(negedge clk);
        end
        if (stop_lo) begin
            rx_wire = 1'b0;
            repeat (16) @(negedge clk);
        end
        rx_wire = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int n;
        apb_if.S_PADDR = '0; apb_if.S_PWRITE = 1'b0; apb_if.S_PSELx = 1'b0;
        apb_if.S_PENABLE = 1'b0; apb_if.S_PWDATA = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_prdata", apb_if.S_PRDATA, 0);
        chk("rst_pready", apb_if.S_PREADY, 0);
        chk("rst_irq", irq, 0);
        reset = 1'b1;
        @(negedge clk);
        apb_rd(UART_RX_ADDR_STATUS, d); chk("rst_status", d, 0);
        apb_rd(UART_RX_ADDR_COUNT, d);  chk("rst_count", d, 0);
        apb_wr(UART_RX_ADDR_DATA, 16'h1234);
        apb_rd(UART_RX_ADDR_COUNT, d);  chk("data_wr_ignored", d, 0);
        apb_rd(2'd3, d);                chk("off3_read", d, 0);

        // single byte with irq latency from the falling start edge
        n = 0;
        fork
            send(8'hA5, 1'b0);
            begin
                while (n < 200) begin
                    @(posedge clk); n++;
                    #1 if (irq) break;
                end
            end
        join
        chk("irq_latency", n, 79);
        apb_rd(UART_RX_ADDR_STATUS, d); chk("a5_status", d, 16'h0001);
        apb_if.S_PADDR = UART_RX_ADDR_DATA; apb_if.S_PWRITE = 1'b0;
        apb_if.S_PSELx = 1'b1; apb_if.S_PENABLE = 1'b0;
        @(negedge clk);
        apb_if.S_PENABLE = 1'b1;
        #1 chk("pready_access", apb_if.S_PREADY, 1);
        chk("a5_data", apb_if.S_PRDATA, 16'h00A5);
        @(negedge clk);
        apb_if.S_PSELx = 1'b0; apb_if.S_PENABLE = 1'b0;
        chk("a5_irq_after", irq, 0);
        apb_rd(UART_RX_ADDR_COUNT, d);  chk("a5_count_after", d, 0);

        // glitch
        rx_wire = 1'b0;
        repeat (2) @(negedge clk);
        rx_wire = 1'b1;
        repeat (20) @(negedge clk);
        apb_rd(UART_RX_ADDR_STATUS, d); chk("glitch_status", d, 0);
        apb_rd(UART_RX_ADDR_COUNT, d);  chk("glitch_count", d, 0);

        // frame error then recovery
        send(8'h3C, 1'b1);
        apb_rd(UART_RX_ADDR_STATUS, d); chk("ferr_status", d, 16'h0008);
        apb_rd(UART_RX_ADDR_COUNT, d);  chk("ferr_count", d, 0);
        apb_wr(UART_RX_ADDR_STATUS, 16'h0008);
        apb_rd(UART_RX_ADDR_STATUS, d); chk("ferr_cleared", d, 0);
        send(8'h11, 1'b0);
        apb_rd(UART_RX_ADDR_DATA, d);   chk("after_ferr_data", d, 16'h0011);

        // overrun
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
        apb_rd(UART_RX_ADDR_COUNT, d);  chk("ovr_count", d, 8);
        apb_rd(UART_RX_ADDR_STATUS, d); chk("ovr_status", d, 16'h0007);
        for (int i = 1; i <= 8; i++) begin
            apb_rd(UART_RX_ADDR_DATA, d); chk($sformatf("ovr_rd%0d", i), d, 16'(i));
        end
        apb_rd(UART_RX_ADDR_DATA, d);   chk("ovr_rd_empty", d, 0);
        apb_wr(UART_RX_ADDR_STATUS, 16'h0004);
        apb_rd(UART_RX_ADDR_STATUS, d); chk("ovr_cleared", d, 0);

        // push and pop on the same edge while full
        for (int i = 0; i < 8; i++) send(8'h21 + 8'(i), 1'b0);
        fork
            send(8'h29, 1'b0);
            begin
                repeat (77) @(negedge clk);
                apb_rd(UART_RX_ADDR_DATA, d);
            end
        join
        chk("pp_read_oldest", d, 16'h0021);
        apb_rd(UART_RX_ADDR_COUNT, d);  chk("pp_count", d, 8);
        apb_rd(UART_RX_ADDR_STATUS, d); chk("pp_status", d, 16'h0003);
        for (int i = 0; i < 8; i++) begin
            apb_rd(UART_RX_ADDR_DATA, d); chk($sformatf("pp_drain%0d", i), d, 16'h22 + 16'(i));
        end

        // reset in the middle of a frame, with a byte pending beforehand
        send(8'h77, 1'b0);
        chk("pre_rst_irq", irq, 1);
        fork
            send(8'hFF, 1'b0);
            begin
                repeat (44) @(negedge clk);
                reset = 1'b0;
                #1;
                chk("midrst_irq", irq, 0);
                chk("midrst_prdata", apb_if.S_PRDATA, 0);
                chk("midrst_pready", apb_if.S_PREADY, 0);
                @(negedge clk); @(negedge clk);
                reset = 1'b1;
            end
        join
        apb_rd(UART_RX_ADDR_COUNT, d);  chk("midrst_count", d, 0);
        send(8'h5A, 1'b0);
        apb_rd(UART_RX_ADDR_DATA, d);   chk("midrst_next_data", d, 16'h005A);
        apb_rd(UART_RX_ADDR_COUNT, d);  chk("midrst_final_count", d, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
